// File: rtl/posit_mult_out_buf.sv
// Result FIFO behind the posit multiplier: captures products on done, presents them
// first-word fall-through over valid/ready, and keeps sticky drop plus NaR/zero counters.
module posit_mult_out_buf #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done,
    input  logic [N-1:0]  in_out,
    input  logic          in_inf,
    input  logic          in_zero,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [N-1:0]  m_data,
    output logic          m_inf,
    output logic          m_zero,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          drop,
    output logic [CW-1:0] nar_cnt,
    output logic [CW-1:0] zero_cnt,
    input  logic          clr
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_EV   = CW'(1);

    logic [N-1:0]  mem_data [DEPTH];
    logic          mem_inf  [DEPTH];
    logic          mem_zero [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic [N-1:0]  norm_data;

    // Handshake: a head entry transfers on any rising edge where m_valid and m_ready are
    // both high; m_valid depends only on registered occupancy, never on done.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign push    = done & (~full | pop);

    always_comb begin
        norm_data = in_out;
        if (in_inf) begin
            norm_data = {1'b1, {(N-1){1'b0}}};
        end else if (in_zero) begin
            norm_data = '0;
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr, so the write lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wr_ptr] <= norm_data;
            mem_inf[wr_ptr]  <= in_inf;
            mem_zero[wr_ptr] <= in_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (push && !pop) begin
                count <= count + ONE_CNT;
            end else if (pop && !push) begin
                count <= count - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            drop     <= 1'b0;
            nar_cnt  <= '0;
            zero_cnt <= '0;
        end else begin
            if (done && !push) begin
                drop <= 1'b1;
            end
            if (push && in_inf && nar_cnt != CNT_MAX) begin
                nar_cnt <= nar_cnt + ONE_EV;
            end
            if (push && in_zero && !in_inf && zero_cnt != CNT_MAX) begin
                zero_cnt <= zero_cnt + ONE_EV;
            end
        end
    end

    assign m_data = m_valid ? mem_data[rd_ptr] : '0;
    assign m_inf  = m_valid ? mem_inf[rd_ptr]  : 1'b0;
    assign m_zero = m_valid ? mem_zero[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_posit_mult_out_buf.sv
// Bench for posit_mult_out_buf: directed scenarios plus random traffic against a queue model.
module tb_posit_mult_out_buf;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, done, in_inf, in_zero, m_ready, clr;
    logic [N-1:0]  in_out;
    logic          m_valid, m_inf, m_zero, full, empty, drop;
    logic [N-1:0]  m_data;
    logic [2:0]    count;
    logic [CW-1:0] nar_cnt, zero_cnt;

    posit_mult_out_buf #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .done(done), .in_out(in_out), .in_inf(in_inf),
        .in_zero(in_zero), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_inf(m_inf), .m_zero(m_zero), .full(full), .empty(empty), .count(count),
        .drop(drop), .nar_cnt(nar_cnt), .zero_cnt(zero_cnt), .clr(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         inf;
        logic         zero;
    } entry_t;

    entry_t exp_q[$];
    int     m_drop, m_nar, m_zc;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        entry_t h;
        h = '{data: '0, inf: 1'b0, zero: 1'b0};
        if (exp_q.size() != 0) h = exp_q[0];
        check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        check("m_data", 32'(m_data), 32'(h.data));
        check("m_inf", 32'(m_inf), 32'(h.inf));
        check("m_zero", 32'(m_zero), 32'(h.zero));
        check("count", 32'(count), 32'(exp_q.size()));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("drop", 32'(drop), 32'(m_drop));
        check("nar_cnt", 32'(nar_cnt), 32'(m_nar));
        check("zero_cnt", 32'(zero_cnt), 32'(m_zc));
    endtask

    // One clock: drive inputs, advance the reference model across the edge, then compare.
    task automatic cycle(input logic r, input logic d, input logic [N-1:0] data,
                         input logic inf, input logic zr, input logic rdy, input logic c);
        bit     was_full, do_pop, do_push;
        entry_t e;
        rst = r; done = d; in_out = data; in_inf = inf; in_zero = zr; m_ready = rdy; clr = c;
        was_full = (exp_q.size() == DEPTH);
        do_pop   = (exp_q.size() != 0) && rdy;
        do_push  = d && (!was_full || do_pop);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_drop = 0; m_nar = 0; m_zc = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.data = inf ? 16'h8000 : (zr ? 16'h0000 : data);
                e.inf  = inf;
                e.zero = zr;
                exp_q.push_back(e);
            end
            if (c) begin
                m_drop = 0; m_nar = 0; m_zc = 0;
            end else begin
                if (d && !do_push) m_drop = 1;
                if (do_push && inf && m_nar < CMAX) m_nar++;
                if (do_push && zr && !inf && m_zc < CMAX) m_zc++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic push_val(input logic [N-1:0] v, input logic rdy);
        cycle(1'b0, 1'b1, v, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        m_drop = 0; m_nar = 0; m_zc = 0;
        rst = 1'b1; done = 1'b0; in_out = '0; in_inf = 1'b0; in_zero = 1'b0;
        m_ready = 1'b0; clr = 1'b0;
        #2;

        // Reset with done active
        cycle(1'b1, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        // Single pass, head held while not ready
        push_val(16'h4000, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill and overflow, then drain
        for (int i = 1; i <= 5; i++) push_val(16'(i), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full plus simultaneous pop, with wrap-around
        for (int i = 1; i <= 4; i++) push_val(16'(i), 1'b0);
        push_val(16'h0009, 1'b1);
        push_val(16'h000a, 1'b1);
        push_val(16'h000b, 1'b1);
        push_val(16'h000c, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Special values
        cycle(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h00ff, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Saturation and clr
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic, including occasional clr and reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_mult_out_buf.md
Name: posit_mult_out_buf

Overview:
- Downstream result stage for the posit multiplier. Captures each product (out/inf/zero) on the multiplier's done strobe and stores it in a DEPTH-entry FIFO.
- Presents results to the consumer over a valid/ready handshake, with first-word fall-through.
- Keeps sticky drop status and saturating NaR/zero event counters for debug readback.
- Exports full so the issuing logic can gate start.

Parameters:
- N, 16, posit width; must match the multiplier.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, log2(DEPTH), pointer width; derived, do not override.
- CW, 16, width of each event counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- done  input  1  multiplier result strobe; one result per cycle when high.
- in_out  input  N  multiplier posit result.
- in_inf  input  1  multiplier NaR flag.
- in_zero  input  1  multiplier zero flag.
- m_valid  output  1  head entry valid.
- m_ready  input  1  consumer accepts head.
- m_data  output  N  head posit.
- m_inf  output  1  head NaR flag.
- m_zero  output  1  head zero flag.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  occupancy, 0..DEPTH.
- drop  output  1  sticky; a result was lost because the FIFO was full.
- nar_cnt  output  CW  saturating count of accepted NaR results.
- zero_cnt  output  CW  saturating count of accepted zero results.
- clr  input  1  synchronous clear of drop, nar_cnt and zero_cnt.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and count go to 0; empty=1; full=0; m_valid=0; drop=0; counters=0.
  - m_data, m_inf and m_zero read 0 while empty.
  - Reset overrides every other input in the same cycle, including done, m_ready and clr.
  - Reset mid-stream discards all stored entries.
- Push: push = done & (~full | pop).
  - The entry written is {in_out, in_inf, in_zero}.
  - Normalisation on write: if in_inf=1, the data stored is 1 followed by N-1 zeros. Else if in_zero=1, the data stored is all zeros. in_inf takes priority over in_zero.
- Pop: pop = m_valid & m_ready. The read pointer advances on the edge where pop is true.
- Fall-through latency:
  - An entry pushed at edge t is visible on m_* from edge t (m_valid high in the cycle after done).
  - There is no combinational path from done to m_valid.
  - m_data, m_inf and m_zero are driven from the storage entry at rd_ptr and stay stable while m_valid=1 and m_ready=0.
- Count:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - Pointers are AW bits and wrap modulo DEPTH.
- Full with a simultaneous pop: the push is accepted and the entry is written into the slot being freed. No drop.
- Full without a pop: done=1 sets drop=1, the entry is discarded, and counters and pointers are unchanged.
- Empty with m_ready=1: no pop, no underflow, count stays 0.
- Counters:
  - nar_cnt increments on an accepted push with in_inf=1.
  - zero_cnt increments on an accepted push with in_zero=1 and in_inf=0.
  - Both saturate at 2^CW-1 and never wrap.
- clr:
  - Clears drop, nar_cnt and zero_cnt at the edge. FIFO contents are untouched.
  - If an event occurs in the same cycle, clr wins: the result is 0, not 1.
- full, empty and count are registered-state decodes and change only at clock edges.

Test Plan:
- Reset with done=1: assert rst for 2 cycles, pulse done with in_out=16'h4000 during reset -> after release count=0, m_valid=0, empty=1, drop=0.
- Single pass: done at cycle 0 with 16'h4000, m_ready=0 -> m_valid=1, m_data=16'h4000 from cycle 1 and held stable. Raise m_ready -> m_valid=0 the next cycle.
- Fill and overflow: 5 consecutive done cycles with 16'h0001..16'h0005, m_ready=0 -> full=1, count=4, drop=1. Draining yields 0001, 0002, 0003, 0004 in order and 0005 is lost.
- Full plus simultaneous pop:
  - FIFO full with 0001..0004; done with 16'h0009 and m_ready=1 in the same cycle -> drop stays 0, count stays 4.
  - Draining yields 0002, 0003, 0004, 0009.
  - Wrap-around checked over 3 further full cycles.
- Special values: done with in_inf=1, in_out=16'h1234 -> m_data=16'h8000, m_inf=1, nar_cnt=1. Then done with in_zero=1, in_out=16'h00FF -> m_data=16'h0000, zero_cnt=1.
- Saturation and clr: CW=4, push 17 NaR results while draining -> nar_cnt stays at 15. clr together with a NaR push -> nar_cnt=0. Next NaR push -> nar_cnt=1.
